// File: rtl/multi_freq_counter_if.sv
// Result stream of multi_freq_counter: one channel count per beat with valid/ready handshake.
interface multi_freq_counter_if #(
   parameter int N_CH  = 4,
   parameter int CNT_W = 24
);
   localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

   logic             result_valid;
   logic             result_ready;
   logic [CH_W-1:0]  result_ch;
   logic [CNT_W-1:0] result_count;
   logic             result_ovf;

   modport master (
      output result_valid,
      output result_ch,
      output result_count,
      output result_ovf,
      input  result_ready
   );

   modport slave (
      input  result_valid,
      input  result_ch,
      input  result_count,
      input  result_ovf,
      output result_ready
   );
endinterface

// File: rtl/multi_freq_counter.sv
// N-channel gated frequency counter: counts synchronised rising edges for a programmable
// gate window, snapshots every channel, then streams the results one channel per beat.
module multi_freq_counter #(
   parameter int N_CH        = 4,
   parameter int CNT_W       = 24,
   parameter int GATE_W      = 24,
   parameter int SYNC_STAGES = 2
) (
   input  logic               Clock,
   input  logic               nReset,
   input  logic [N_CH-1:0]    in_signal,
   input  logic               enable,
   input  logic               continuous,
   input  logic [GATE_W-1:0]  gate_cycles,
   input  logic               start,
   output logic               busy,
   multi_freq_counter_if.master res
);
   localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;
   localparam logic [CH_W-1:0]   LAST_CH  = CH_W'(N_CH - 1);
   localparam logic [CH_W-1:0]   CH_ONE   = {{(CH_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [GATE_W-1:0] GATE_ONE = {{(GATE_W-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GATE  = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   state_t                 state_r;
   logic [SYNC_STAGES-1:0] sync_r [N_CH];
   logic [N_CH-1:0]        prev_r;
   logic [N_CH-1:0]        edge_s;
   logic [CNT_W-1:0]       cnt_r [N_CH];
   logic [N_CH-1:0]        ovf_r;
   logic [CNT_W-1:0]       cnt_nxt_s [N_CH];
   logic [N_CH-1:0]        ovf_nxt_s;
   logic [CNT_W-1:0]       snap_cnt_r [N_CH];
   logic [N_CH-1:0]        snap_ovf_r;
   logic [GATE_W-1:0]      gate_len_r;
   logic [GATE_W-1:0]      gate_len_s;
   logic [GATE_W-1:0]      timer_r;
   logic [CH_W-1:0]        ch_idx_r;
   logic [CH_W-1:0]        ch_idx_nxt_s;
   logic                   valid_r;
   logic [CNT_W-1:0]       count_r;
   logic                   res_ovf_r;
   logic                   busy_r;

   assign gate_len_s   = (gate_cycles == {GATE_W{1'b0}}) ? GATE_ONE : gate_cycles;
   assign ch_idx_nxt_s = ch_idx_r + CH_ONE;

   assign busy             = busy_r;
   assign res.result_valid = valid_r;
   assign res.result_ch    = ch_idx_r;
   assign res.result_count = count_r;
   assign res.result_ovf   = res_ovf_r;

   // Synchronisers and previous-value registers run in every state so edges are clean at gate start.
   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         for (int c = 0; c < N_CH; c++) begin
            sync_r[c] <= {SYNC_STAGES{1'b0}};
         end
         prev_r <= {N_CH{1'b0}};
      end else begin
         for (int c = 0; c < N_CH; c++) begin
            sync_r[c] <= {sync_r[c][SYNC_STAGES-2:0], in_signal[c]};
            prev_r[c] <= sync_r[c][SYNC_STAGES-1];
         end
      end
   end

   // Rising-edge detect on the synchronised inputs.
   always_comb begin
      edge_s = {N_CH{1'b0}};
      for (int c = 0; c < N_CH; c++) begin
         edge_s[c] = sync_r[c][SYNC_STAGES-1] & ~prev_r[c];
      end
   end

   // Saturating next count: an edge arriving at all-ones is lost and marks the channel overflowed.
   always_comb begin
      ovf_nxt_s = ovf_r;
      for (int c = 0; c < N_CH; c++) begin
         cnt_nxt_s[c] = cnt_r[c];
         if (edge_s[c]) begin
            if (cnt_r[c] == CNT_MAX) begin
               ovf_nxt_s[c] = 1'b1;
            end else begin
               cnt_nxt_s[c] = cnt_r[c] + CNT_ONE;
            end
         end else begin
            cnt_nxt_s[c] = cnt_r[c];
         end
      end
   end

   // Measurement FSM: gate timing, counting, snapshot and result streaming.
   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         state_r    <= ST_IDLE;
         gate_len_r <= {GATE_W{1'b0}};
         timer_r    <= {GATE_W{1'b0}};
         ch_idx_r   <= {CH_W{1'b0}};
         valid_r    <= 1'b0;
         count_r    <= {CNT_W{1'b0}};
         res_ovf_r  <= 1'b0;
         busy_r     <= 1'b0;
         ovf_r      <= {N_CH{1'b0}};
         snap_ovf_r <= {N_CH{1'b0}};
         for (int c = 0; c < N_CH; c++) begin
            cnt_r[c]      <= {CNT_W{1'b0}};
            snap_cnt_r[c] <= {CNT_W{1'b0}};
         end
      end else if (!enable) begin
         state_r   <= ST_IDLE;
         timer_r   <= {GATE_W{1'b0}};
         ch_idx_r  <= {CH_W{1'b0}};
         valid_r   <= 1'b0;
         count_r   <= {CNT_W{1'b0}};
         res_ovf_r <= 1'b0;
         busy_r    <= 1'b0;
         ovf_r     <= {N_CH{1'b0}};
         for (int c = 0; c < N_CH; c++) begin
            cnt_r[c] <= {CNT_W{1'b0}};
         end
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (start) begin
                  gate_len_r <= gate_len_s;
                  timer_r    <= {GATE_W{1'b0}};
                  busy_r     <= 1'b1;
                  state_r    <= ST_GATE;
               end
            end
            ST_GATE: begin
               if (timer_r == (gate_len_r - GATE_ONE)) begin
                  // Last gate cycle: its own edges go straight into the snapshot.
                  for (int c = 0; c < N_CH; c++) begin
                     snap_cnt_r[c] <= cnt_nxt_s[c];
                     cnt_r[c]      <= {CNT_W{1'b0}};
                  end
                  snap_ovf_r <= ovf_nxt_s;
                  ovf_r      <= {N_CH{1'b0}};
                  timer_r    <= {GATE_W{1'b0}};
                  ch_idx_r   <= {CH_W{1'b0}};
                  valid_r    <= 1'b1;
                  count_r    <= cnt_nxt_s[0];
                  res_ovf_r  <= ovf_nxt_s[0];
                  state_r    <= ST_DRAIN;
               end else begin
                  for (int c = 0; c < N_CH; c++) begin
                     cnt_r[c] <= cnt_nxt_s[c];
                  end
                  ovf_r   <= ovf_nxt_s;
                  timer_r <= timer_r + GATE_ONE;
               end
            end
            ST_DRAIN: begin
               if (res.result_ready) begin
                  if (ch_idx_r == LAST_CH) begin
                     ch_idx_r  <= {CH_W{1'b0}};
                     valid_r   <= 1'b0;
                     count_r   <= {CNT_W{1'b0}};
                     res_ovf_r <= 1'b0;
                     if (continuous) begin
                        gate_len_r <= gate_len_s;
                        timer_r    <= {GATE_W{1'b0}};
                        state_r    <= ST_GATE;
                     end else begin
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                     end
                  end else begin
                     ch_idx_r  <= ch_idx_nxt_s;
                     count_r   <= snap_cnt_r[ch_idx_nxt_s];
                     res_ovf_r <= snap_ovf_r[ch_idx_nxt_s];
                  end
               end
            end
            default: begin
               state_r   <= ST_IDLE;
               ch_idx_r  <= {CH_W{1'b0}};
               valid_r   <= 1'b0;
               count_r   <= {CNT_W{1'b0}};
               res_ovf_r <= 1'b0;
               busy_r    <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: doc/multi_freq_counter.md
Name: multi_freq_counter

Overview:
- N-channel gated frequency counter; the parametrised successor to the single-channel freq_measurement block in the frequency-counter FPGA design.
- Counts rising edges on each asynchronous chip-output input during a programmable gate window of Clock cycles.
- Snapshots all channel counts at the end of each gate, then streams them out one channel per beat over a valid/ready interface.
- Supports single-shot and continuous modes; counts saturate with a per-channel overflow flag.

Parameters:
N_CH, 4, number of measured input channels (1..16)
CNT_W, 24, edge-counter and result width per channel
GATE_W, 24, width of the gate-length port and gate timer
SYNC_STAGES, 2, flip-flop synchroniser depth per channel (>=2)

Ports:
Clock  input  1  system clock, all state on rising edge
nReset  input  1  asynchronous active-low reset
in_signal  input  N_CH  asynchronous signals under measurement
enable  input  1  block enable; low aborts and holds IDLE
continuous  input  1  1 = re-arm automatically after drain, 0 = single-shot
gate_cycles  input  GATE_W  gate length in Clock cycles, sampled at gate start
start  input  1  single-cycle request to begin a measurement
busy  output  1  high in GATE or DRAIN
result_valid  output  1  result beat available
result_ready  input  1  consumer accepts beat when high with result_valid
result_ch  output  $clog2(N_CH) (min 1)  channel index of current beat
result_count  output  CNT_W  rising-edge count for result_ch
result_ovf  output  1  count for result_ch saturated

Behaviour:
- Reset (nReset low, async): state IDLE; all synchronisers, edge registers, counters, snapshots and the gate timer are 0. Outputs: busy=0, result_valid=0, result_ch=0, result_count=0, result_ovf=0.
- Input path, per channel: SYNC_STAGES-deep synchroniser, then a prev register (always clocked, in every state). Edge pulse = sync_out & ~prev.
  - An input rise is counted SYNC_STAGES+1 cycles later.
  - Pulses shorter than one Clock period are not guaranteed to be counted.
- States:
  - IDLE: counters held at 0. Move to GATE when enable & start, latching gate_len = max(gate_cycles,1) and clearing the timer.
  - GATE: lasts exactly gate_len cycles. Each cycle, every channel whose edge pulse is high increments its counter. At CNT_W all-ones the counter holds and its sticky ovf bit sets. On the last gate cycle (timer = gate_len-1), edges of that cycle are included. Next cycle: copy counters and ovf bits to snapshots, clear counters, enter DRAIN with ch_idx=0.
  - DRAIN: result_valid=1 with result_ch=ch_idx and snapshot[ch_idx] driven. Beat completes when result_valid & result_ready; then ch_idx increments. The data must stay stable while valid is high and ready is low. After beat N_CH-1 completes: if continuous & enable, enter GATE the next cycle (re-latching gate_cycles); otherwise enter IDLE.
- start is ignored outside IDLE.
- continuous=1 in IDLE still requires start to arm the first measurement.
- Edges arriving in IDLE or DRAIN are not counted.
- enable low in any state: next cycle go to IDLE, clear counters, timer and ch_idx, and drop result_valid. A partially drained result is discarded.
- Outputs are registered. result_count and result_ovf read 0 whenever result_valid=0.
- result_ch wraps only via return to 0 on leaving DRAIN. It never exceeds N_CH-1.
- Simultaneous start and enable fall: enable wins, and the block stays in IDLE.

Test Plan:
1. Clock 1 MHz, N_CH=4, gate_cycles=100. ch0 square wave with period 10 clocks, ch1 held 0, ch2 period 4, ch3 held 1. Pulse start. Expect beats (0,10,0), (1,0,0), (2,25,0), (3,0,0) in order; busy falls after beat 3; state returns to IDLE.
2. CNT_W=4, gate_cycles=100, ch0 period 5 (20 edges). Expect result_count=15, result_ovf=1 for ch0; other channels unaffected.
3. Backpressure: as scenario 1, but hold result_ready low for 7 cycles on each beat. Values and order are identical, and result_count stays stable while stalled.
4. continuous=1, gate_cycles=50, ch0 period 10. Expect repeated 4-beat bursts with ch0 count 5 each. Then drop enable mid-GATE: result_valid and busy reach 0 within 1 cycle, and no further beats appear.
5. gate_cycles=0: expect a 1-cycle gate. An edge aligned to the gate gives count 1, otherwise 0. Then assert nReset low mid-DRAIN: all outputs are 0 immediately (asynchronous).
6. start pulsed during GATE: ignored, and the gate length is unchanged (verified by count 10 for ch0 in the scenario-1 setup).
